// File: rtl/lcd_frame_receiver_pkg.sv
// Shared LCD video types: panel geometry, frame-buffer sizing and receiver state encoding.
package lcd_frame_receiver_pkg;

    localparam int LCD_LINEWIDTH      = 160;
    localparam int LCD_LINES          = 144;
    localparam int LCD_BYTES_PER_LINE = LCD_LINEWIDTH / 4;
    localparam int LCD_FB_BYTES       = 5760;
    localparam int LCD_FB_ADDR_BITS   = 13;

    typedef logic [1:0] Pixel;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } RxState;

endpackage

// File: rtl/lcd_frame_receiver_packer.sv
// Packs four 2-bit pixels into one byte, pixel 0 in the MS bits; slot 0 always starts a fresh byte.
module lcd_pixel_packer
    import lcd_frame_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       discard,
    input  logic [1:0] slot,
    input  Pixel       pix,
    output logic [7:0] pack_byte
);

    logic [7:0] pack_q;
    logic [7:0] base;

    // pack_byte already includes the incoming pixel so a full byte is available in the 4th pixel's cycle
    always_comb begin
        base      = (discard || slot == 2'd0) ? 8'h00 : pack_q;
        pack_byte = base;
        case (slot)
            2'd0:    pack_byte[7:6] = pix;
            2'd1:    pack_byte[5:4] = pix;
            2'd2:    pack_byte[3:2] = pix;
            default: pack_byte[1:0] = pix;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_q <= 8'h00;
        end else if (discard) begin
            pack_q <= 8'h00;
        end else if (load) begin
            pack_q <= pack_byte;
        end
    end

endmodule

// File: rtl/lcd_frame_receiver.sv
// Receives the PPU pixel stream, checks line/frame geometry and writes packed frames to the frame buffer.
module lcd_frame_receiver
    import lcd_frame_receiver_pkg::*;
#(
    parameter int LINE_WIDTH = LCD_LINEWIDTH,
    parameter int NUM_LINES  = LCD_LINES,
    parameter int FB_ADDR_W  = LCD_FB_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lcd_enable,
    input  logic                 pix_valid,
    input  Pixel                 pix_data,
    input  logic                 pix_sof,
    input  logic                 pix_eol,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_wdata,
    output logic                 frame_done,
    output logic [7:0]           frame_count,
    output logic                 err_short_line,
    output logic                 err_long_line,
    output logic                 err_sof
);

    localparam int XW  = $clog2(LINE_WIDTH);
    localparam int YW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int BPL = LINE_WIDTH / 4;

    localparam logic [0:0] ST_IDLE = 1'(RX_IDLE);
    localparam logic [0:0] ST_RECV = 1'(RX_RECV);

    logic [0:0]           state;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [FB_ADDR_W-1:0] line_base;

    logic                 proc, sof_err, at_last, last_line;
    logic                 short_line, long_line, byte_done;
    logic [XW-1:0]        cur_x;
    logic [YW-1:0]        cur_y;
    logic [FB_ADDR_W-1:0] cur_base;
    logic [7:0]           pack_byte;

    // A sof pixel is always treated as position (0,0), whatever the counters held
    always_comb begin
        proc       = pix_valid && lcd_enable && (state == ST_RECV || pix_sof);
        sof_err    = pix_valid && lcd_enable && pix_sof && state == ST_RECV;
        cur_x      = pix_sof ? '0 : x;
        cur_y      = pix_sof ? '0 : y;
        cur_base   = pix_sof ? '0 : line_base;
        at_last    = (cur_x == XW'(LINE_WIDTH - 1));
        last_line  = (cur_y == YW'(NUM_LINES - 1));
        short_line = proc && pix_eol && !at_last;
        long_line  = proc && at_last && !pix_eol;
        byte_done  = proc && !short_line && (cur_x[1:0] == 2'b11);
    end

    lcd_pixel_packer u_packer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (proc && !short_line),
        .discard  (!lcd_enable || short_line),
        .slot     (cur_x[1:0]),
        .pix      (pix_data),
        .pack_byte(pack_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            x              <= '0;
            y              <= '0;
            line_base      <= '0;
            fb_we          <= 1'b0;
            fb_addr        <= '0;
            fb_wdata       <= 8'h00;
            frame_done     <= 1'b0;
            frame_count    <= 8'h00;
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_sof        <= 1'b0;
        end else begin
            fb_we          <= 1'b0;
            frame_done     <= 1'b0;
            err_sof        <= sof_err;
            err_short_line <= short_line && !sof_err;
            err_long_line  <= long_line && !sof_err;
            if (!lcd_enable) begin
                state     <= ST_IDLE;
                x         <= '0;
                y         <= '0;
                line_base <= '0;
            end else if (proc) begin
                if (byte_done) begin
                    fb_we    <= 1'b1;
                    fb_addr  <= cur_base + FB_ADDR_W'(cur_x >> 2);
                    fb_wdata <= pack_byte;
                end
                if (short_line || long_line) begin
                    state     <= ST_IDLE;
                    x         <= '0;
                    y         <= '0;
                    line_base <= '0;
                end else if (at_last) begin
                    x <= '0;
                    if (last_line) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        state       <= ST_IDLE;
                        y           <= '0;
                        line_base   <= '0;
                    end else begin
                        state     <= ST_RECV;
                        y         <= cur_y + YW'(1);
                        line_base <= cur_base + FB_ADDR_W'(BPL);
                    end
                end else begin
                    state     <= ST_RECV;
                    x         <= cur_x + XW'(1);
                    y         <= cur_y;
                    line_base <= cur_base;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_receiver.sv
// Scoreboard bench for lcd_frame_receiver on a reduced 16x8 geometry.
module tb_lcd_frame_receiver;

    localparam int LW  = 16;
    localparam int NL  = 8;
    localparam int AW  = 5;
    localparam int BPL = LW / 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lcd_enable = 1'b0;
    logic       pix_valid = 1'b0;
    logic [1:0] pix_data = 2'd0;
    logic       pix_sof = 1'b0;
    logic       pix_eol = 1'b0;

    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          err_short_line, err_long_line, err_sof;

    always #5 clk = ~clk;

    lcd_frame_receiver #(
        .LINE_WIDTH(LW),
        .NUM_LINES (NL),
        .FB_ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lcd_enable    (lcd_enable),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_wdata      (fb_wdata),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .err_short_line(err_short_line),
        .err_long_line (err_long_line),
        .err_sof       (err_sof)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          done;
    } wr_t;

    wr_t        sb_q[$];
    wr_t        mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_wr = 0, n_done = 0, n_short = 0, n_long = 0, n_sof = 0;
    logic [7:0] exp_fc = 8'h00;
    logic       saw_fc_zero = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] tb_acc = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (fb_we) begin
                n_wr++;
                mem[fb_addr] = fb_wdata;
                last_addr = fb_addr;
                if (sb_q.size() == 0) begin
                    check_val("write_unexpected", {27'd0, fb_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("wr_addr", {27'd0, fb_addr}, {27'd0, mon_e.addr});
                    check_val("wr_data", {24'd0, fb_wdata}, {24'd0, mon_e.data});
                    check_val("wr_done", {31'd0, frame_done}, {31'd0, mon_e.done});
                end
            end else if (frame_done) begin
                check_val("done_without_we", 32'd1, 32'd0);
            end
            if (frame_done) begin
                n_done++;
                exp_fc = exp_fc + 8'd1;
                check_val("frame_count", {24'd0, frame_count}, {24'd0, exp_fc});
                if (frame_count == 8'h00) saw_fc_zero = 1'b1;
            end
            if (err_short_line) n_short++;
            if (err_long_line)  n_long++;
            if (err_sof)        n_sof++;
        end
    end

    task automatic drive(input logic v, input logic [1:0] d, input logic s, input logic e);
        @(posedge clk);
        #1;
        pix_valid = v;
        pix_data  = d;
        pix_sof   = s;
        pix_eol   = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // pixel (x,y) = (x+y)%4; a write is expected on every 4th pixel when push is set
    task automatic send_px(input int x, input int y, input logic s, input logic e, input logic push);
        logic [1:0] p;
        wr_t        w;
        p = 2'((x + y) % 4);
        if (x % 4 == 0) tb_acc = 8'h00;
        tb_acc = tb_acc | (8'(p) << (6 - 2 * (x % 4)));
        if (push && (x % 4 == 3)) begin
            w.addr = AW'(y * BPL + x / 4);
            w.data = tb_acc;
            w.done = (y == NL - 1) && (x == LW - 1);
            sb_q.push_back(w);
        end
        drive(1'b1, p, s, e);
    endtask

    task automatic send_lines(input int y0, input int y1, input logic gaps);
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < LW; x++) begin
                if (gaps && (x % 5 == 2)) drive(1'b0, 2'd3, 1'b1, 1'b1);
                send_px(x, y, (x == 0 && y == 0), (x == LW - 1), 1'b1);
            end
        end
    endtask

    task automatic drain(input string tag);
        idle(3);
        check_val(tag, sb_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] outs_word();
        return {9'd0, fb_we, 3'd0, fb_addr, fb_wdata, frame_done, frame_count,
                err_short_line, err_long_line, err_sof};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, s0, l0, e0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outs", outs_word(), 32'd0);
        reset_n    = 1'b1;
        lcd_enable = 1'b1;
        idle(2);

        // Full frame
        w0 = n_wr;
        send_lines(0, NL, 1'b0);
        drain("sb_drain_frame1");
        check_val("frame1_writes", n_wr - w0, 32'd32);
        check_val("addr0_data", {24'd0, mem[0]}, 32'h1B);
        check_val("line1_data", {24'd0, mem[BPL]}, 32'h6C);
        check_val("frame1_done", n_done, 32'd1);
        check_val("frame1_count", {24'd0, frame_count}, 32'd1);

        // Junk before sof, then a frame with invalid sof/eol cycles mixed in
        w0 = n_wr;
        for (int i = 0; i < 10; i++) drive(1'b1, 2'(i), 1'b0, (i == 5));
        idle(2);
        check_val("no_write_before_sof", n_wr - w0, 32'd0);
        send_lines(0, NL, 1'b1);
        drain("sb_drain_frame2");
        check_val("frame2_writes", n_wr - w0, 32'd32);
        check_val("frame2_count", {24'd0, frame_count}, 32'd2);
        check_val("frame2_errs", n_short + n_long + n_sof, 32'd0);

        // Short line: eol on a byte boundary pixel, no write for it
        d0 = n_done; s0 = n_short; l0 = n_long;
        send_lines(0, 5, 1'b0);
        for (int x = 0; x < 12; x++) send_px(x, 5, 1'b0, (x == 11), (x < 8));
        for (int x = 12; x < LW; x++) send_px(x, 5, 1'b0, (x == LW - 1), 1'b0);
        drain("sb_drain_short");
        check_val("short_pulse", n_short - s0, 32'd1);
        check_val("short_last_addr", {27'd0, last_addr}, 32'(5 * BPL + 1));
        check_val("short_no_done", n_done - d0, 32'd0);
        check_val("short_no_long", n_long - l0, 32'd0);

        // sof mid-frame landing on a byte boundary pixel
        s0 = n_sof;
        send_lines(0, 6, 1'b0);
        for (int x = 0; x < 7; x++) send_px(x, 6, 1'b0, 1'b0, 1'b1);
        send_lines(0, NL, 1'b0);
        drain("sb_drain_sof");
        check_val("sof_pulse", n_sof - s0, 32'd1);
        check_val("sof_frame_count", {24'd0, frame_count}, 32'd3);

        // lcd_enable dropped mid-line for 3 cycles
        w0 = n_wr;
        send_lines(0, 4, 1'b0);
        for (int x = 0; x < 6; x++) send_px(x, 4, 1'b0, 1'b0, 1'b1);
        for (int x = 6; x < 9; x++) begin
            send_px(x, 4, 1'b0, 1'b0, 1'b0);
            lcd_enable = 1'b0;
        end
        for (int x = 9; x < LW; x++) begin
            send_px(x, 4, 1'b0, (x == LW - 1), 1'b0);
            lcd_enable = 1'b1;
        end
        idle(3);
        check_val("enable_drop_count", {24'd0, frame_count}, 32'd3);
        check_val("enable_drop_writes", n_wr - w0, 32'd17);
        send_lines(0, NL, 1'b0);
        drain("sb_drain_enable");
        check_val("enable_new_frame", {24'd0, frame_count}, 32'd4);

        // Long line: last byte written, then nothing until sof
        d0 = n_done; l0 = n_long; e0 = n_short;
        send_lines(0, 2, 1'b0);
        for (int x = 0; x < LW; x++) send_px(x, 2, 1'b0, 1'b0, 1'b1);
        for (int x = LW; x < LW + 5; x++) send_px(x, 2, 1'b0, (x == LW + 4), 1'b0);
        drain("sb_drain_long");
        check_val("long_pulse", n_long - l0, 32'd1);
        check_val("long_last_addr", {27'd0, last_addr}, 32'(2 * BPL + 3));
        check_val("long_no_done", n_done - d0, 32'd0);
        check_val("long_no_short", n_short - e0, 32'd0);

        // 256 back-to-back frames wrap frame_count
        for (int f = 0; f < 256; f++) send_lines(0, NL, 1'b0);
        drain("sb_drain_wrap");
        check_val("fc_wrapped", {31'd0, saw_fc_zero}, 32'd1);
        check_val("fc_after_256", {24'd0, frame_count}, 32'd4);

        // Asynchronous reset mid-frame
        for (int x = 0; x < 4; x++) send_px(x, 0, (x == 0), 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check_val("we_before_reset", {31'd0, fb_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("async_reset_outs", outs_word(), 32'd0);
        sb_q.delete();
        pix_valid = 1'b0;
        exp_fc    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);
        check_val("post_reset_outs", outs_word(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
